// File: rtl/monitor_read_responder.sv
// Monitor register read responder: strobes one register read and
// returns the word to the host as a SLIP-framed byte stream.
module monitor_read_responder #(
  parameter logic [7:0] RESP_GROUP = 8'h20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_addr_i,
  output logic        read_en_o,
  output logic [15:0] addr_o,
  input  logic [15:0] data_in_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o
);

  localparam logic [7:0] END     = 8'hC0;
  localparam logic [7:0] ESC     = 8'hDB;
  localparam logic [7:0] ESC_END = 8'hDC;
  localparam logic [7:0] ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    CAPTURE,
    SEND
  } state_t;

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [2:0]  idx_q;
  logic        esc_q;
  logic        open_q;
  logic        close_q;
  logic        read_en_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  logic [2:0]  idx_d;
  logic [7:0]  byte_d;
  logic        esc_d;
  logic [7:0]  esc2_d;
  logic        tx_fire;

  function automatic logic [7:0] pl_byte(
    input logic [2:0]  i,
    input logic [15:0] a,
    input logic [15:0] d
  );
    logic [7:0] b;
    case (i)
      3'd0:    b = RESP_GROUP;
      3'd1:    b = a[15:8];
      3'd2:    b = a[7:0];
      3'd3:    b = d[15:8];
      3'd4:    b = d[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign tx_fire     = tx_valid_q & tx_ready_i;
  assign cmd_ready_o = (state_q == IDLE) & ~rst_i;
  assign busy_o      = (state_q != IDLE);
  assign read_en_o   = read_en_q;
  assign addr_o      = addr_q;
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;

  // Next payload byte to present and whether it needs an escape pair.
  always_comb begin
    idx_d  = open_q ? 3'd0 : 3'(idx_q + 3'd1);
    byte_d = pl_byte(idx_d, addr_q, data_q);
    esc_d  = (byte_d == END) || (byte_d == ESC);
    esc2_d = (pl_byte(idx_q, addr_q, data_q) == END) ? ESC_END
                                                     : ESC_ESC;
  end

  // Command/strobe/capture sequencing and framed byte emission.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      idx_q      <= 3'd0;
      esc_q      <= 1'b0;
      open_q     <= 1'b0;
      close_q    <= 1'b0;
      read_en_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      read_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q    <= cmd_addr_i;
            read_en_q <= 1'b1;
            state_q   <= STROBE;
          end
        end
        STROBE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          data_q     <= data_in_i;
          idx_q      <= 3'd0;
          esc_q      <= 1'b0;
          open_q     <= 1'b1;
          close_q    <= 1'b0;
          tx_data_q  <= END;
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (tx_fire) begin
            if (close_q) begin
              close_q    <= 1'b0;
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end else if (esc_q) begin
              tx_data_q <= esc2_d;
              esc_q     <= 1'b0;
            end else if (!open_q && idx_q == 3'd4) begin
              close_q   <= 1'b1;
              tx_data_q <= END;
            end else begin
              open_q    <= 1'b0;
              idx_q     <= idx_d;
              esc_q     <= esc_d;
              tx_data_q <= esc_d ? ESC : byte_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_read_responder.sv
// Randomized bench for monitor_read_responder with a
// queue-based SLIP frame reference model.
module tb_monitor_read_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [15:0] data_in = 16'h0;
  logic        tx_ready = 1'b1;

  logic        ra_rdy, ra_re, ra_txv, ra_busy;
  logic [15:0] ra_addr;
  logic [7:0]  ra_txd;
  logic        rg_rdy, rg_re, rg_txv, rg_busy;
  logic [15:0] rg_addr;
  logic [7:0]  rg_txd;

  always #5 clk = ~clk;

  monitor_read_responder dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (ra_rdy),
    .cmd_addr_i  (cmd_addr),
    .read_en_o   (ra_re),
    .addr_o      (ra_addr),
    .data_in_i   (data_in),
    .tx_data_o   (ra_txd),
    .tx_valid_o  (ra_txv),
    .tx_ready_i  (tx_ready),
    .busy_o      (ra_busy)
  );

  monitor_read_responder #(.RESP_GROUP(8'hC0)) dut_g (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (rg_rdy),
    .cmd_addr_i  (cmd_addr),
    .read_en_o   (rg_re),
    .addr_o      (rg_addr),
    .data_in_i   (data_in),
    .tx_data_o   (rg_txd),
    .tx_valid_o  (rg_txv),
    .tx_ready_i  (tx_ready),
    .busy_o      (rg_busy)
  );

  logic        sel = 1'b0;
  logic        s_rdy, s_re, s_txv, s_busy;
  logic [15:0] s_addr;
  logic [7:0]  s_txd;

  assign s_rdy  = sel ? rg_rdy  : ra_rdy;
  assign s_re   = sel ? rg_re   : ra_re;
  assign s_txv  = sel ? rg_txv  : ra_txv;
  assign s_busy = sel ? rg_busy : ra_busy;
  assign s_addr = sel ? rg_addr : ra_addr;
  assign s_txd  = sel ? rg_txd  : ra_txd;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;
  logic [15:0] rdata = 16'h0;
  logic        seen = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         gcyc[$];
  int         re_q[$];
  int         rdy_cyc = -1;
  logic       prev_stall = 1'b0;
  logic       prev_re = 1'b0;
  logic [7:0] prev_d = 8'h0;

  task automatic chk(input string tag,
                     input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  // Reference frame: END, escaped payload, END.
  function automatic void build(input logic [7:0] g,
                                input logic [15:0] a,
                                input logic [15:0] d);
    logic [7:0] pl[5];
    pl = '{g, a[15:8], a[7:0], d[15:8], d[7:0]};
    exp_q.delete();
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 5; i++) begin
      if (pl[i] == 8'hC0) begin
        exp_q.push_back(8'hDB);
        exp_q.push_back(8'hDC);
      end else if (pl[i] == 8'hDB) begin
        exp_q.push_back(8'hDB);
        exp_q.push_back(8'hDD);
      end else begin
        exp_q.push_back(pl[i]);
      end
    end
    exp_q.push_back(8'hC0);
  endfunction

  function automatic logic [7:0] rb();
    int p;
    p = $urandom_range(0, 3);
    if (p == 0) return 8'hC0;
    if (p == 1) return 8'hDB;
    return 8'($urandom);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Register model: word valid only in the cycle after read_en.
  always @(posedge clk) begin
    #1;
    data_in = seen ? rdata : 16'($urandom);
    case (mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    seen = s_re;
    if (rst) begin
      prev_stall = 1'b0;
      prev_re = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_v", s_txv, 1);
        chk("hold_d", s_txd, prev_d);
      end
      if (s_re) begin
        chk("re_pair", prev_re, 0);
        re_q.push_back(cyc);
      end
      if (s_txv && tx_ready) begin
        got.push_back(s_txd);
        gcyc.push_back(cyc);
      end
      if (s_rdy && rdy_cyc < 0) rdy_cyc = cyc;
      prev_stall = s_txv && !tx_ready;
      prev_d = s_txd;
      prev_re = s_re;
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!s_rdy && k < 200);
    chk("cmd_wait", s_rdy, 1);
  endtask

  task automatic settle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((ra_busy || rg_busy) && k < 200);
    chk("settle", ra_busy | rg_busy, 0);
  endtask

  task automatic do_read(input logic [15:0] a,
                         input logic [15:0] d,
                         input bit pulse);
    int n;
    int len;
    int k;
    build(sel ? 8'hC0 : 8'h20, a, d);
    len = exp_q.size();
    wait_ready();
    got.delete();
    gcyc.delete();
    re_q.delete();
    rdy_cyc = -1;
    rdata = d;
    cmd_addr = a;
    cmd_valid = 1'b1;
    n = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr = 16'($urandom);
    for (k = 0; k < 400 && got.size() < len; k++) begin
      @(negedge clk);
      #1;
      if (pulse && k == 3) begin
        chk("busy_rdy", s_rdy, 0);
        cmd_valid = 1'b1;
        cmd_addr = 16'h0010;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("len", got.size(), len);
    for (int i = 0; i < len; i++)
      chk($sformatf("byte%0d", i),
          i < got.size() ? 32'(got[i]) : 32'hDEAD,
          exp_q[i]);
    chk("re_cnt", re_q.size(), 1);
    if (re_q.size() > 0) chk("re_cyc", re_q[0], n + 1);
    chk("end_txv", s_txv, 0);
    chk("end_busy", s_busy, 0);
    chk("end_addr", s_addr, a);
    if (got.size() == len) begin
      chk("rdy_cyc", rdy_cyc, gcyc[len-1] + 1);
      if (mode == 0) begin
        chk("first_cyc", gcyc[0], n + 3);
        chk("last_cyc", gcyc[len-1], n + 2 + len);
      end
    end
  endtask

  initial begin
    int k;
    logic [15:0] a;
    logic [15:0] d;

    repeat (3) @(negedge clk);
    chk("rst_rdy", s_rdy, 0);
    chk("rst_re", s_re, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_txv", s_txv, 0);
    chk("rst_txd", s_txd, 0);
    chk("rst_busy", s_busy, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_rdy", s_rdy, 1);

    mode = 0;
    do_read(16'h0001, 16'h1234, 1'b0);
    do_read(16'h00DB, 16'hC0DB, 1'b0);
    mode = 1;
    do_read(16'h0001, 16'h1234, 1'b0);
    mode = 0;
    do_read(16'h0020, 16'h5678, 1'b1);

    wait_ready();
    got.delete();
    rdata = 16'hABCD;
    cmd_addr = 16'h0003;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (got.size() < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_bytes", got.size(), 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_txv", s_txv, 0);
    chk("mid_busy", s_busy, 0);
    chk("mid_re", s_re, 0);
    chk("mid_addr", s_addr, 0);
    chk("mid_txd", s_txd, 0);
    chk("mid_rdy", s_rdy, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rel", s_rdy, 1);
    do_read(16'h0002, 16'h0000, 1'b0);

    settle();
    sel = 1'b1;
    do_read(16'h0000, 16'h0000, 1'b0);
    mode = 2;
    for (int i = 0; i < 8; i++) begin
      a = {rb(), rb()};
      d = {rb(), rb()};
      do_read(a, d, 1'b0);
    end
    mode = 0;
    settle();
    sel = 1'b0;

    for (int i = 0; i < 24; i++) begin
      mode = (i % 3 == 0) ? 0 : 2;
      a = {rb(), rb()};
      d = {rb(), rb()};
      do_read(a, d, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/monitor_read_responder.md
# monitor_read_responder

Host-side read responder for the monitor register file. Accepts a read command carrying a 16-bit monitor address from the host command parser and issues a one-cycle `read_en`/`addr` strobe to the monitor registers. It then captures the returned 16-bit word and emits a SLIP-framed read-response message as a byte stream toward the USB transmit FIFO. It sits between the command decoder and the monitor register read port, on the return path to the host.

## Interface
- `RESP_GROUP`, default 8'h20: group byte placed first in every response payload. It is escaped like any other payload byte.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  a read command is presented.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_addr`  in  16  monitor register address to read.
- `read_en`  out  1  one-cycle read strobe to the monitor register file.
- `addr`  out  16  address to the monitor register file; held from strobe until next command.
- `data_in`  in  16  monitor register read data; valid exactly 1 cycle after `read_en`.
- `tx_data`  out  8  outgoing byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  downstream accepts byte when `tx_valid & tx_ready`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - **IDLE**: `cmd_ready`=1. Command accepted on `cmd_valid & cmd_ready`; latch `cmd_addr` into `addr`; go to STROBE.
  - **STROBE**: `read_en`=1 for this cycle only; go to CAPTURE.
  - **CAPTURE**: register `data_in` into the data latch; byte index=0; go to SEND.
  - **SEND**: emit the message, one byte per handshake; return to IDLE after the final END is accepted.
- Message byte order:
  - END 8'hC0
  - payload: `RESP_GROUP`, `addr[15:8]`, `addr[7:0]`, `data[15:8]`, `data[7:0]`
  - END 8'hC0
- Escaping, applied to payload bytes only:
  - 8'hC0 is sent as 8'hDB then 8'hDC.
  - 8'hDB is sent as 8'hDB then 8'hDD.
  - All other bytes pass unchanged.
  - Implement with an escape-pending flag plus a 3-bit payload index (0..4).
- Message length is 7 bytes minimum and 12 maximum (all five payload bytes escaped).
- `cmd_valid` outside IDLE is ignored. The command is not queued; the upstream must hold it until `cmd_ready`.
- Address and data are latched; changes on `cmd_addr`/`data_in` after capture do not affect the message in flight.

## Timing
- Reset values:
  - `cmd_ready`=0 while `rst` is high, then 1 (IDLE).
  - `read_en`=0, `addr`=16'h0000, `tx_valid`=0, `tx_data`=8'h00, `busy`=0.
- Command accepted at edge N:
  - `read_en`=1 in cycle N+1.
  - `data_in` sampled at the end of cycle N+2.
  - `tx_valid`=1 with 8'hC0 from cycle N+3.
- `tx_data` and `tx_valid` are registered.
  - While `tx_valid & ~tx_ready`, `tx_data` holds stable and `tx_valid` stays 1.
  - Each accepted byte presents the next byte on the following cycle; there are no bubbles while `tx_ready`=1.
- With `tx_ready` held at 1, a 7-byte message occupies cycles N+3..N+9. `cmd_ready` rises in cycle N+10. Command-to-command throughput is 10 cycles for an unescaped message.
- Reset asserted mid-operation: all outputs return to reset values asynchronously, and the partial message is abandoned without a closing END. After reset the block resumes in IDLE.
- `read_en` is never high for two consecutive cycles.

## Test plan
- **Basic read:** `cmd_addr`=16'h0001, `data_in`=16'h1234 one cycle after `read_en`, `tx_ready`=1.
  - Expect `read_en` pulse at N+1.
  - Expect bytes C0 20 00 01 12 34 C0 on consecutive cycles N+3..N+9.
  - Expect `cmd_ready` high at N+10.
- **Escaping:** `cmd_addr`=16'h00DB, `data_in`=16'hC0DB.
  - Expect C0 20 00 DB DD DB DC DB DD C0 (10 bytes).
- **Backpressure:** same as the basic read, with `tx_ready` toggling 0/1 every cycle.
  - Expect identical byte sequence.
  - Each byte held stable while `tx_ready`=0; no byte dropped or duplicated.
- **Command during busy:** pulse `cmd_valid` with 16'h0010 while in SEND.
  - Expect no `read_en`, no second message, and `cmd_ready`=0 throughout.
- **Reset mid-message:** assert `rst` after the 3rd byte is accepted.
  - Expect `tx_valid`=0 and `busy`=0 immediately.
  - After release, a new command to 16'h0002 with data 16'h0000 produces C0 20 00 02 00 00 C0.
- **Parameter escape:** `RESP_GROUP`=8'hC0, `cmd_addr`=16'h0000, `data_in`=16'h0000.
  - Expect C0 DB DC 00 00 00 00 C0.
